// File: rtl/clock_pkg.sv
// Shared types, field limits and wrap-aware step helpers for the clock time-setting logic.
package clock_pkg;

  typedef enum logic [2:0] {StRun, StSetH, StSetM, StSetS, StCommit} state_e;

  localparam int unsigned HOURS_W  = 5;
  localparam int unsigned MINSEC_W = 6;

  localparam logic [HOURS_W-1:0]  HOURS_MAX  = 5'd23;
  localparam logic [MINSEC_W-1:0] MINSEC_MAX = 6'd59;

  function automatic logic [HOURS_W-1:0] step_hours(input logic [HOURS_W-1:0] v,
                                                    input logic up, input logic dn);
    step_hours = v;
    if (up) begin
      step_hours = (v == HOURS_MAX) ? '0 : v + 5'd1;
    end else if (dn) begin
      step_hours = (v == '0) ? HOURS_MAX : v - 5'd1;
    end
  endfunction

  function automatic logic [MINSEC_W-1:0] step_minsec(input logic [MINSEC_W-1:0] v,
                                                      input logic up, input logic dn);
    step_minsec = v;
    if (up) begin
      step_minsec = (v == MINSEC_MAX) ? '0 : v + 6'd1;
    end else if (dn) begin
      step_minsec = (v == '0) ? MINSEC_MAX : v - 6'd1;
    end
  endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Signal bundle between the set controller and its surroundings (buttons, counter, display).
interface clock_set_ctrl_if;
  import clock_pkg::*;

  logic                seconds_pulse_i;
  logic                inc_i;
  logic                dec_i;
  logic                config_i;
  logic [HOURS_W-1:0]  hours_i;
  logic [MINSEC_W-1:0] minutes_i;
  logic [MINSEC_W-1:0] seconds_i;
  logic                run_en_o;
  logic                load_o;
  logic [HOURS_W-1:0]  load_hours_o;
  logic [MINSEC_W-1:0] load_minutes_o;
  logic [MINSEC_W-1:0] load_seconds_o;
  logic [2:0]          field_sel_o;
  logic                blink_o;

  // Controller side.
  modport master (
    input  seconds_pulse_i, inc_i, dec_i, config_i, hours_i, minutes_i, seconds_i,
    output run_en_o, load_o, load_hours_o, load_minutes_o, load_seconds_o, field_sel_o,
    blink_o
  );

  // Environment side: buttons, counter and display.
  modport slave (
    output seconds_pulse_i, inc_i, dec_i, config_i, hours_i, minutes_i, seconds_i,
    input  run_en_o, load_o, load_hours_o, load_minutes_o, load_seconds_o, field_sel_o,
    blink_o
  );
endinterface

// File: rtl/btn_step_gen.sv
// Rising-edge detect plus hold-to-repeat; emits a one-cycle step pulse per edge and repeat tick.
module btn_step_gen #(
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 20_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic step
);

  localparam int unsigned CntW = $clog2(REPEAT_DELAY + 1);
  // After a repeat tick, reload so the next tick lands REPEAT_PERIOD cycles later.
  localparam logic [CntW-1:0] Reload = CntW'(REPEAT_DELAY - REPEAT_PERIOD + 1);

  logic            prev_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            edge_det, rpt;

  always_comb begin
    edge_det = level & ~prev_q;
    rpt      = 1'b0;
    cnt_d    = cnt_q;
    if (!level) begin
      cnt_d = '0;
    end else if (edge_det) begin
      cnt_d = CntW'(1);
    end else if (cnt_q == '0) begin
      // Held since before reset: no edge seen, so no repeat either.
      cnt_d = '0;
    end else if (cnt_q == CntW'(REPEAT_DELAY)) begin
      rpt   = 1'b1;
      cnt_d = Reload;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  assign step = edge_det | rpt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      prev_q <= level;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: edits a shadow copy of h/m/s with the counter frozen, then loads it.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 20_000_000,
  parameter int unsigned BLINK_HALF    = 25_000_000,
  parameter int unsigned TIMEOUT_S     = 30
) (
  input  logic                   clk_100MHz_i,
  input  logic                   reset_i,
  clock_set_ctrl_if.master       bus
);

  localparam int unsigned IdleW  = $clog2(TIMEOUT_S + 1);
  localparam int unsigned BlinkW = $clog2(BLINK_HALF + 1);

  state_e              state_q, state_d;
  logic                cfg_prev_q;
  logic                cfg_edge, inc_step, dec_step, up, dn;
  logic [HOURS_W-1:0]  hrs_q, hrs_d;
  logic [MINSEC_W-1:0] min_q, min_d, sec_q, sec_d;
  logic [IdleW-1:0]    idle_q, idle_d;
  logic [BlinkW-1:0]   blink_cnt_q, blink_cnt_d;
  logic                blink_q, blink_d;

  btn_step_gen #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_inc (
    .clk   (clk_100MHz_i),
    .rst   (reset_i),
    .level (bus.inc_i),
    .step  (inc_step)
  );

  btn_step_gen #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_dec (
    .clk   (clk_100MHz_i),
    .rst   (reset_i),
    .level (bus.dec_i),
    .step  (dec_step)
  );

  assign cfg_edge = bus.config_i & ~cfg_prev_q;
  assign up       = inc_step & ~dec_step;
  assign dn       = dec_step & ~inc_step;

  always_comb begin
    state_d     = state_q;
    hrs_d       = hrs_q;
    min_d       = min_q;
    sec_d       = sec_q;
    idle_d      = idle_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;

    unique case (state_q)
      StRun: begin
        idle_d = '0;
        if (cfg_edge) begin
          hrs_d   = bus.hours_i;
          min_d   = bus.minutes_i;
          sec_d   = bus.seconds_i;
          state_d = StSetH;
        end
      end
      StSetH, StSetM, StSetS: begin
        if (cfg_edge) begin
          idle_d  = '0;
          state_d = (state_q == StSetH) ? StSetM : (state_q == StSetM) ? StSetS : StCommit;
        end else if (inc_step || dec_step) begin
          idle_d = '0;
          if (state_q == StSetH) hrs_d = step_hours(hrs_q, up, dn);
          if (state_q == StSetM) min_d = step_minsec(min_q, up, dn);
          if (state_q == StSetS) sec_d = step_minsec(sec_q, up, dn);
        end else if (bus.seconds_pulse_i) begin
          if (idle_q == IdleW'(TIMEOUT_S - 1)) begin
            idle_d  = '0;
            state_d = StRun;
          end else begin
            idle_d = idle_q + IdleW'(1);
          end
        end
      end
      StCommit: state_d = StRun;
      default:  state_d = StRun;
    endcase

    // Blink restarts on every field change and stays dark outside the edit states.
    if (state_d != state_q || !(state_d inside {StSetH, StSetM, StSetS})) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (blink_cnt_q == BlinkW'(BLINK_HALF - 1)) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BlinkW'(1);
    end
  end

  always_comb begin
    bus.field_sel_o = 3'b000;
    unique case (state_q)
      StSetH:  bus.field_sel_o = 3'b100;
      StSetM:  bus.field_sel_o = 3'b010;
      StSetS:  bus.field_sel_o = 3'b001;
      default: bus.field_sel_o = 3'b000;
    endcase
  end

  assign bus.run_en_o       = (state_q == StRun);
  assign bus.load_o         = (state_q == StCommit);
  assign bus.load_hours_o   = hrs_q;
  assign bus.load_minutes_o = min_q;
  assign bus.load_seconds_o = sec_q;
  assign bus.blink_o        = blink_q;

  always_ff @(posedge clk_100MHz_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StRun;
      cfg_prev_q  <= 1'b1;
      hrs_q       <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      idle_q      <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_prev_q  <= bus.config_i;
      hrs_q       <= hrs_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      idle_q      <= idle_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

endmodule
